// File: rtl/hazard_pkg.sv
// Shared encodings, the shadow-entry type and the register-match helper
// used by the hazard controller and its stage registers.
package hazard_pkg;

  // D-stage bypass selects
  localparam logic [1:0] SEL_GRF  = 2'b00;
  localparam logic [1:0] SEL_E    = 2'b01;
  localparam logic [1:0] SEL_M    = 2'b10;
  localparam logic [1:0] SEL_W    = 2'b11;

  // E-stage bypass selects
  localparam logic [1:0] SEL_PIPE = 2'b00;
  localparam logic [1:0] SEL_EM   = 2'b01;
  localparam logic [1:0] SEL_EW   = 2'b10;

  localparam logic [1:0] TUSE_NONE = 2'd3;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic [1:0] tnew;
  } stage_t;

  // Register 0 is hard-wired, so it never matches a producer.
  function automatic logic stage_match(input stage_t s, input logic [4:0] r);
    return (r != 5'd0) && (s.dst == r);
  endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline entry: loads every edge, optionally as a bubble,
// with optional tnew decrement (saturating) or tnew clear.
module hazard_stage_reg
  import hazard_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  stage_t d,
  input  logic   bubble,
  input  logic   dec,
  input  logic   clr_tnew,
  output stage_t q
);

  stage_t nxt;

  always_comb begin
    nxt = d;
    if (bubble)
      nxt = '0;
    else if (clr_tnew)
      nxt.tnew = 2'd0;
    else if (dec && (d.tnew != 2'd0))
      nxt.tnew = d.tnew - 2'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      q <= '0;
    else
      q <= nxt;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks E/M/W producers in shadow entries and
// derives stall plus D- and E-stage bypass selects.
module hazard_ctrl
  import hazard_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic [4:0]  d_dst,
  input  logic [1:0]  d_tnew,
  output logic        stall,
  output logic [1:0]  fwd_d_rs_sel,
  output logic [1:0]  fwd_d_rt_sel,
  output logic [1:0]  fwd_e_rs_sel,
  output logic [1:0]  fwd_e_rt_sel,
  output logic [15:0] stall_cnt
);

  stage_t d_entry, m_in, e_q, m_q, w_q;
  logic   unused_src;

  assign d_entry = '{rs: d_rs, rt: d_rt, dst: d_dst, tnew: d_tnew};
  // M and W only track the producer side, so sources are dropped here.
  assign m_in    = '{rs: 5'd0, rt: 5'd0, dst: e_q.dst, tnew: e_q.tnew};

  hazard_stage_reg u_e (
    .clk(clk), .reset(reset), .d(d_entry), .bubble(stall),
    .dec(1'b0), .clr_tnew(1'b0), .q(e_q)
  );

  hazard_stage_reg u_m (
    .clk(clk), .reset(reset), .d(m_in), .bubble(1'b0),
    .dec(1'b1), .clr_tnew(1'b0), .q(m_q)
  );

  hazard_stage_reg u_w (
    .clk(clk), .reset(reset), .d(m_q), .bubble(1'b0),
    .dec(1'b0), .clr_tnew(1'b1), .q(w_q)
  );

  assign unused_src = ^{m_q.rs, m_q.rt, w_q.rs, w_q.rt};

  function automatic logic src_stall(input logic [4:0] r, input logic [1:0] tuse,
                                     input stage_t e, input stage_t m);
    return (tuse != TUSE_NONE) &&
           ((stage_match(e, r) && (e.tnew > tuse)) ||
            (stage_match(m, r) && (m.tnew > tuse)));
  endfunction

  function automatic logic [1:0] d_select(input logic [4:0] r, input stage_t e,
                                          input stage_t m, input stage_t w);
    if (stage_match(e, r))
      return (e.tnew == 2'd0) ? SEL_E : SEL_GRF;
    else if (stage_match(m, r))
      return (m.tnew == 2'd0) ? SEL_M : SEL_GRF;
    else if (stage_match(w, r))
      return (w.tnew == 2'd0) ? SEL_W : SEL_GRF;
    return SEL_GRF;
  endfunction

  function automatic logic [1:0] e_select(input logic [4:0] r, input stage_t m,
                                          input stage_t w);
    if (stage_match(m, r))
      return (m.tnew == 2'd0) ? SEL_EM : SEL_PIPE;
    else if (stage_match(w, r))
      return (w.tnew == 2'd0) ? SEL_EW : SEL_PIPE;
    return SEL_PIPE;
  endfunction

  assign stall = src_stall(d_rs, d_tuse_rs, e_q, m_q) |
                 src_stall(d_rt, d_tuse_rt, e_q, m_q);

  assign fwd_d_rs_sel = d_select(d_rs, e_q, m_q, w_q);
  assign fwd_d_rt_sel = d_select(d_rt, e_q, m_q, w_q);
  assign fwd_e_rs_sel = e_select(e_q.rs, m_q, w_q);
  assign fwd_e_rt_sel = e_select(e_q.rt, m_q, w_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      stall_cnt <= 16'd0;
    else if (stall && (stall_cnt != 16'hFFFF))
      stall_cnt <= stall_cnt + 16'd1;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; ports are named clk and reset (reset=0 means in reset).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  async active-low reset.
REQ-004 d_rs, d_rt  input  5 each  D-stage source register numbers.
REQ-005 d_tuse_rs, d_tuse_rt  input  2 each  cycles from D until operand needed: 0..2; 3 means unused.
REQ-006 d_dst  input  5  D-stage destination register; 0 means no write.
REQ-007 d_tnew  input  2  result latency measured at E entry: 0..2.
REQ-008 stall  output  1  freeze PC and the D register, and insert a bubble into E.
REQ-009 fwd_d_rs_sel, fwd_d_rt_sel  output  2 each  D-stage bypass select: 00 GRF, 01 E, 10 M, 11 W.
REQ-010 fwd_e_rs_sel, fwd_e_rt_sel  output  2 each  E-stage bypass select: 00 D/E register, 01 M, 10 W, 11 reserved.
REQ-011 stall_cnt  output  16  count of stall cycles, saturating.

Function
REQ-012 SHALL hold shadow entries E, M, W; E holds {rs, rt, dst, tnew}, and M and W hold {dst, tnew}.
REQ-013 Each clock edge, when stall=0, SHALL load E from the D inputs.
REQ-014 Each clock edge, when stall=1, SHALL load E with a bubble (all fields 0).
REQ-015 Each clock edge SHALL load M from E, with tnew decremented and saturated at 0.
REQ-016 Each clock edge SHALL load W from M with tnew forced to 0.
REQ-017 Match(stage, r) is true when r!=0 and stage.dst==r.
REQ-018 stall SHALL be combinational, with zero-cycle latency.
REQ-019 stall SHALL be 1 iff, for rs or rt with tuse!=3, Match(E) with E.tnew>tuse, or Match(M) with M.tnew>tuse.
REQ-020 W SHALL never cause a stall.
REQ-021 D-stage select: take the nearest matching stage in order E, M, W.
REQ-022 D-stage select: if that stage's tnew==0, output its code; otherwise output 00.
REQ-023 D-stage select: with no matching stage, output 00.
REQ-024 E-stage select SHALL use the same nearest-match rule over M then W, using the registered E.rs and E.rt.
REQ-025 A match on register 0 SHALL never forward or stall.
REQ-026 When two stages match the same register, the nearer stage SHALL win.
REQ-027 rs and rt SHALL be evaluated independently; rs==rt SHALL produce identical selects.
REQ-028 stall_cnt SHALL increment on every edge where stall=1, and hold at 16'hFFFF.
REQ-029 All outputs except stall_cnt SHALL be combinational from state plus D inputs.
REQ-030 stall_cnt SHALL be registered.

Reset
REQ-031 While reset=0, E, M and W SHALL clear to bubbles immediately, independent of clk.
REQ-032 While reset=0, stall_cnt SHALL clear to 0.
REQ-033 With cleared state, all select outputs SHALL be 00 and stall SHALL be 0, regardless of the D inputs.
REQ-034 Reset asserted mid-stall SHALL drop stall in the same cycle.
REQ-035 stall_cnt SHALL not increment on the first edge after release unless a stall condition exists.

Structure
REQ-036 Shared package hazard_pkg SHALL hold the select encodings (SEL_GRF, SEL_E, SEL_M, SEL_W, SEL_PIPE) and TUSE_NONE=3.
REQ-037 Shared package hazard_pkg SHALL hold the stage-entry typedef.
REQ-038 One sub-module, hazard_stage_reg, SHALL implement a single shadow entry with load, bubble, tnew decrement and async reset.
REQ-039 hazard_stage_reg SHALL be instantiated three times.

Verification
REQ-040 Load-use: D(dst=8,tnew=2), then D(rs=8,tuse_rs=1) -> stall=1 for one cycle, then fwd_e_rs_sel=10 when the producer reaches W; stall_cnt=1.
REQ-041 ALU-to-branch: D(dst=9,tnew=1), then D(rs=9,tuse_rs=0) -> stall=1 for one cycle, then fwd_d_rs_sel=10.
REQ-042 ALU-to-ALU: D(dst=10,tnew=1), then D(rt=10,tuse_rt=1) -> stall=0, and on the next cycle fwd_e_rt_sel=01.
REQ-043 Double match: dst=11 in both M and W, E rs=11 -> fwd_e_rs_sel=01.
REQ-044 Register 0: E.dst=0 with tnew=2, D rs=0 with tuse=0 -> stall=0 and all selects 00.
REQ-045 Reset mid-stall: assert reset while stall=1 -> stall=0, selects=00 and stall_cnt=0 immediately.
REQ-046 Saturation: force 70000 stall cycles -> stall_cnt=16'hFFFF, then stays at 16'hFFFF.
